alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_cmd_fifo.sv | 57 +++++
 rtl/alu_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// the queued command layout and the default queue depth.
package alu_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOT  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } seq_state_e;

    // 20-bit queue entry: operands, opcode and the chain flag.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       chain;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrapping pointers and a separate occupancy
// counter; writes when full and reads when empty are ignored.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  cmd_t             i_wr_data,
    input  logic             i_rd_en,
    output cmd_t             o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;

    // NOTE: payload storage has no reset; occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // NOTE: non-blocking updates so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives a registered 1-cycle-latency ALU, and returns
// each result through a valid/ready response port with an accumulator for chaining.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    input  logic        cmd_chain,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        busy,
    output logic [15:0] rsp_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic             w_pop;
    logic             w_capture;
    logic             w_rsp_fire;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_fifo_count;
    cmd_t             w_head;
    cmd_t             w_cmd_in;

    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [2:0]  r_alu_opcode;
    logic [7:0]  r_acc;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_result;
    logic        r_rsp_carry;
    logic        r_rsp_zero;
    logic [15:0] r_rsp_count;

    assign w_cmd_in = '{a: cmd_a, b: cmd_b, op: cmd_op, chain: cmd_chain};

    alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (cmd_valid),
        .i_wr_data (w_cmd_in),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_fifo_count)
    );

    assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            ST_IDLE: if (!w_empty) begin
                w_pop  = 1'b1;
                w_next = ST_EXEC;
            end
            ST_EXEC: w_next = ST_CAPT;
            ST_CAPT: begin
                w_capture = 1'b1;
                w_next    = ST_RESP;
            end
            ST_RESP: if (rsp_ready) begin
                w_pop  = !w_empty;
                w_next = w_empty ? ST_IDLE : ST_EXEC;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The accumulator is written in CAPT, always before the next pop can occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a      <= 8'h00;
            r_alu_b      <= 8'h00;
            r_alu_opcode <= OP_ADD;
            r_acc        <= 8'h00;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 8'h00;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b1;
            r_rsp_count  <= 16'h0000;
        end else begin
            if (w_pop) begin
                r_alu_a      <= w_head.chain ? r_acc : w_head.a;
                r_alu_b      <= w_head.b;
                r_alu_opcode <= w_head.op;
            end
            if (w_capture) begin
                r_rsp_result <= alu_result;
                r_rsp_carry  <= alu_carry;
                r_rsp_zero   <= alu_zero;
                r_acc        <= alu_result;
                r_rsp_valid  <= 1'b1;
            end else if (w_rsp_fire) begin
                r_rsp_valid  <= 1'b0;
            end
            if (w_rsp_fire && (r_rsp_count != 16'hFFFF)) r_rsp_count <= r_rsp_count + 16'd1;
        end
    end

    assign cmd_ready  = !w_full;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_count  = r_rsp_count;
    assign busy       = (w_fifo_count != '0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Integration bench: the sequencer wrapped with a behavioural registered alu_8bit,
// expected responses queued at push time and compared on each response handshake.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_chain;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic        alu_carry, alu_zero;
    logic        rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy;
    logic [7:0]  rsp_result;
    logic [15:0] rsp_count;
    logic [8:0]  alu_next;

    int         n_checks = 0;
    int         n_pass   = 0;
    rsp_t       sb[$];
    logic [7:0] acc_m;
    int         exp_count;
    logic       hold_prev;
    rsp_t       hold_val;
    rsp_t       mon_e;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_chain  (cmd_chain),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .rsp_count  (rsp_count)
    );

    // alu_8bit reference: {carry, result}; SUB carry is the borrow, reserved ops give 0.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            default: return 9'h000;
        endcase
    endfunction

    assign alu_next = alu_ref(alu_a, alu_b, alu_opcode);

    always @(posedge clk) begin
        alu_result <= alu_next[7:0];
        alu_carry  <= alu_next[8];
        alu_zero   <= (alu_next[7:0] == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one command; queues its expected response if it is accepted.
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op, input logic chain);
        logic [8:0] r;
        logic       accepted;
        int         t;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        accepted = cmd_ready;
        check("push_ready", {31'd0, accepted}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (accepted) begin
            r     = alu_ref(chain ? acc_m : a, b, op);
            acc_m = r[7:0];
            sb.push_back('{res: r[7:0], c: r[8], z: (r[7:0] == 8'h00)});
        end
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
    endtask

    // Response monitor: in-order scoreboard compare on handshake, stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (rsp_valid && hold_prev) begin
                check("stable_result", {24'd0, rsp_result}, {24'd0, hold_val.res});
                check("stable_carry", {31'd0, rsp_carry}, {31'd0, hold_val.c});
                check("stable_zero", {31'd0, rsp_zero}, {31'd0, hold_val.z});
            end
            if (rsp_valid && rsp_ready) begin
                exp_count++;
                n_checks++;
                assert (sb.size() != 0) begin
                    n_pass++;
                end else begin
                    $error("FAIL rsp_unexpected: observed response 0x%0h with empty scoreboard",
                           rsp_result);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_result", {24'd0, rsp_result}, {24'd0, mon_e.res});
                    check("rsp_carry", {31'd0, rsp_carry}, {31'd0, mon_e.c});
                    check("rsp_zero", {31'd0, rsp_zero}, {31'd0, mon_e.z});
                end
                hold_prev = 1'b0;
            end else if (rsp_valid) begin
                hold_prev = 1'b1;
                hold_val  = {rsp_result, rsp_carry, rsp_zero};
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'd0; cmd_chain = 1'b0;
        rsp_ready = 1'b1; acc_m = 8'h00; exp_count = 0;

        // Reset values while rst_n is held low.
        #12;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_result", {24'd0, rsp_result}, 32'h00);
        check("rst_rsp_carry", {31'd0, rsp_carry}, 32'd0);
        check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd1);
        check("rst_alu_a", {24'd0, alu_a}, 32'h00);
        check("rst_alu_b", {24'd0, alu_b}, 32'h00);
        check("rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_count", {16'd0, rsp_count}, 32'd0);

        // First push on the first rising edge after release; ADD 0xFF+0x01 latency.
        @(negedge clk);
        rst_n = 1'b1;
        push_cmd(8'hFF, 8'h01, 3'd0, 1'b0);
        check("first_push_count", {29'd0, dut.u_fifo.o_count}, 32'd1);
        check("first_push_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("pop_alu_a", {24'd0, alu_a}, 32'hFF);
        check("pop_alu_b", {24'd0, alu_b}, 32'h01);
        check("pop_alu_opcode", {29'd0, alu_opcode}, 32'd0);
        check("pop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick(1);
        check("lat1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick(1);
        check("lat2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("add_result", {24'd0, rsp_result}, 32'h00);
        check("add_carry", {31'd0, rsp_carry}, 32'd1);
        check("add_zero", {31'd0, rsp_zero}, 32'd1);
        tick(1);
        check("add_rsp_count", {16'd0, rsp_count}, 32'd1);
        check("add_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
        check("add_idle", {31'd0, busy}, 32'd0);

        // Chain: SUB 0x10-0x01, then SUB acc-0x0F with a ignored.
        push_cmd(8'h10, 8'h01, 3'd1, 1'b0);
        push_cmd(8'h77, 8'h0F, 3'd1, 1'b1);
        wait_drain(40);
        check("chain_result", {24'd0, rsp_result}, 32'h00);
        check("chain_zero", {31'd0, rsp_zero}, 32'd1);
        check("chain_carry", {31'd0, rsp_carry}, 32'd0);

        // Mixed opcodes back to back, including a chained ADD.
        push_cmd(8'hF0, 8'h3C, 3'd2, 1'b0);
        push_cmd(8'h81, 8'h18, 3'd3, 1'b0);
        push_cmd(8'hAA, 8'h0F, 3'd4, 1'b0);
        push_cmd(8'h00, 8'h80, 3'd0, 1'b1);
        push_cmd(8'h5A, 8'h00, 3'd5, 1'b0);
        wait_drain(60);

        // Reserved opcode is forwarded; the ALU's zero result is reported as-is.
        push_cmd(8'hAB, 8'hCD, 3'd6, 1'b0);
        wait_drain(40);
        check("rsv_result", {24'd0, rsp_result}, 32'h00);
        check("rsv_zero", {31'd0, rsp_zero}, 32'd1);
        check("rsv_carry", {31'd0, rsp_carry}, 32'd0);

        // Backpressure: five commands while the first is held in RESP.
        rsp_ready = 1'b0;
        push_cmd(8'h01, 8'h01, 3'd0, 1'b0);
        push_cmd(8'h00, 8'h03, 3'd0, 1'b1);
        push_cmd(8'h40, 8'h50, 3'd1, 1'b0);
        push_cmd(8'h00, 8'hFF, 3'd4, 1'b1);
        push_cmd(8'hC3, 8'h3C, 3'd3, 1'b0);
        tick(2);
        check("bp_count", {29'd0, dut.u_fifo.o_count}, 32'd4);
        check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_busy", {31'd0, busy}, 32'd1);
        cmd_a = 8'hEE; cmd_b = 8'hEE; cmd_op = 3'd0; cmd_chain = 1'b0; cmd_valid = 1'b1;
        tick(1);
        check("full_push_ignored", {29'd0, dut.u_fifo.o_count}, 32'd4);

        // Push and pop on the same edge at full occupancy: only the pop happens.
        rsp_ready = 1'b1;
        check("full_pp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick(1);
        cmd_valid = 1'b0;
        check("full_pp_count", {29'd0, dut.u_fifo.o_count}, 32'd3);
        check("full_pp_ready_after", {31'd0, cmd_ready}, 32'd1);
        wait_drain(80);
        check("bp_rsp_count", {16'd0, rsp_count}, exp_count);

        // Reset while in CAPT with two entries queued.
        push_cmd(8'h01, 8'h02, 3'd0, 1'b0);
        push_cmd(8'h03, 8'h04, 3'd0, 1'b0);
        push_cmd(8'h05, 8'h06, 3'd0, 1'b0);
        check("pre_rst_count", {29'd0, dut.u_fifo.o_count}, 32'd2);
        check("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_alu_a", {24'd0, alu_a}, 32'h00);
        check("mid_rst_alu_b", {24'd0, alu_b}, 32'h00);
        check("mid_rst_rsp_result", {24'd0, rsp_result}, 32'h00);
        check("mid_rst_rsp_zero", {31'd0, rsp_zero}, 32'd1);
        check("mid_rst_rsp_count", {16'd0, rsp_count}, 32'd0);
        check("mid_rst_count", {29'd0, dut.u_fifo.o_count}, 32'd0);
        sb.delete();
        acc_m = 8'h00;
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        push_cmd(8'h99, 8'h05, 3'd0, 1'b1);
        tick(1);
        check("post_rst_chain_alu_a", {24'd0, alu_a}, 32'h00);
        wait_drain(40);
        check("post_rst_chain_result", {24'd0, rsp_result}, 32'h05);
        check("final_rsp_count", {16'd0, rsp_count}, exp_count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
